// File: rtl/bitty_pkg.sv
// Shared command codes, ack byte and FSM state set for the bitty memory responder.
// Define BITTY_MEM_STORE_ACK_EN to add the SEND_ACK/WAIT_ACK states for STORE acknowledgement.
package bitty_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h00;
  localparam logic [7:0] CMD_STORE = 8'h01;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_DHI,
    GET_DLO,
    RD,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO
`ifdef BITTY_MEM_STORE_ACK_EN
    ,
    SEND_ACK,
    WAIT_ACK
`endif
  } state_e;

  function automatic logic is_valid_cmd(input logic [7:0] b);
    return (b == CMD_LOAD) || (b == CMD_STORE);
  endfunction

  // States in which tx_en is high for their single cycle.
  function automatic logic is_send(input state_e s);
`ifdef BITTY_MEM_STORE_ACK_EN
    return (s == SEND_HI) || (s == SEND_LO) || (s == SEND_ACK);
`else
    return (s == SEND_HI) || (s == SEND_LO);
`endif
  endfunction

endpackage

// File: rtl/bitty_mem_array.sv
// Word storage for the responder: synchronous write, one-cycle registered read,
// asynchronous active-low clear of every word.
module bitty_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: reset must clear every word, so this is a flop array with async clear,
  // not an inferable RAM (RAM macros cannot be reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bitty_mem_responder.sv
// Host-side memory server answering bitty LOAD/STORE frames over a byte UART.
// Define BITTY_MEM_STORE_ACK_EN to send ACK_BYTE after every completed STORE.
module bitty_mem_responder
  import bitty_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_done,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] err_cnt
);

  state_e              state_q, state_d;
  logic                store_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          dhi_q;
  logic                tx_en_q;
  logic                busy_q;
  logic [7:0]          err_cnt_q;
  logic [DATA_W-1:0]   rd_data;
  logic                rx_accept;
  logic                err_evt;
  logic [7:0]          tx_data_c;

  bitty_mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    ((state_q == GET_DLO) && rx_done),
    .waddr_i (addr_q),
    .wdata_i ({dhi_q, rx_data}),
    .re_i    (state_q == RD),
    .raddr_i (addr_q),
    .rdata_o (rd_data)
  );

  // Bytes are only consumed while collecting a frame; anything else is an overrun.
  assign rx_accept = (state_q == IDLE) || (state_q == GET_ADDR) ||
                     (state_q == GET_DHI) || (state_q == GET_DLO);
  assign err_evt   = rx_done && (!rx_accept || ((state_q == IDLE) && !is_valid_cmd(rx_data)));

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_done && is_valid_cmd(rx_data)) state_d = GET_ADDR;
      GET_ADDR: if (rx_done) state_d = store_q ? GET_DHI : RD;
      GET_DHI:  if (rx_done) state_d = GET_DLO;
`ifdef BITTY_MEM_STORE_ACK_EN
      GET_DLO:  if (rx_done) state_d = SEND_ACK;
      SEND_ACK: state_d = WAIT_ACK;
      WAIT_ACK: if (tx_done) state_d = IDLE;
`else
      GET_DLO:  if (rx_done) state_d = IDLE;
`endif
      RD:       state_d = SEND_HI;
      SEND_HI:  state_d = WAIT_HI;
      WAIT_HI:  if (tx_done) state_d = SEND_LO;
      SEND_LO:  state_d = WAIT_LO;
      WAIT_LO:  if (tx_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      store_q   <= 1'b0;
      addr_q    <= '0;
      dhi_q     <= '0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tx_en_q <= is_send(state_d);
      busy_q  <= (state_d != IDLE);
      if ((state_q == IDLE) && rx_done)     store_q <= (rx_data == CMD_STORE);
      if ((state_q == GET_ADDR) && rx_done) addr_q  <= rx_data[ADDR_W-1:0];
      if ((state_q == GET_DHI) && rx_done)  dhi_q   <= rx_data;
      if (err_evt && (err_cnt_q != 8'hFF))  err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // The read register holds the word from RD until the next LOAD, so it can feed tx_data directly.
  always_comb begin
    tx_data_c = 8'h00;
    case (state_q)
      SEND_HI, WAIT_HI: tx_data_c = rd_data[DATA_W-1 -: 8];
      SEND_LO, WAIT_LO: tx_data_c = rd_data[7:0];
`ifdef BITTY_MEM_STORE_ACK_EN
      SEND_ACK, WAIT_ACK: tx_data_c = ACK_BYTE;
`endif
      default: tx_data_c = 8'h00;
    endcase
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_c;
  assign busy    = busy_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_bitty_mem_responder.sv
// Randomized self-checking bench for bitty_mem_responder: the bench plays both UART
// ends and checks every cycle against a word-array / byte-queue model.
module tb_bitty_mem_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       busy;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  bitty_mem_responder #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .tx_done (tx_done),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [15:0] mem_model [256];
  logic [7:0] exp_q [$];
  int         err_exp = 0;
  bit         outstanding = 1'b0;
  logic [7:0] held = 8'h00;

  logic [7:0] hi, lo, ack, a;
  int         lat, op;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void bump_err();
    if (err_exp < 255) err_exp++;
  endfunction

  // Per-cycle compare against the model: error count, transmitted bytes, hold behaviour.
  always @(negedge clk) begin
    if (!reset) begin
      outstanding = 1'b0;
    end else begin
      check("err_cnt", 32'(err_cnt), 32'(err_exp));
      if (tx_en) begin
        check("tx_en_before_tx_done", 32'(outstanding), 32'd0);
        check("tx_en_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        outstanding = 1'b1;
        held = tx_data;
      end else if (outstanding) begin
        check("tx_data_hold", 32'(tx_data), 32'(held));
        if (tx_done) outstanding = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic wait_tx(output logic [7:0] b, output int n);
    b = 8'h00;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      n++;
      if (tx_en) begin
        b = tx_data;
        return;
      end
    end
    check("tx_en_timeout", 32'(tx_en), 32'd1);
  endtask

  // Acts as the UART transmitter: tx_done after a random delay; mode 1 injects an
  // rx byte during the wait, mode 2 injects one in the same cycle as tx_done.
  task automatic respond(input int mode);
    @(posedge clk); #1;
    idle($urandom_range(0, 3));
    if (mode == 1) begin
      rx_data = 8'($urandom);
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      bump_err();
      idle($urandom_range(0, 2));
    end
    tx_done = 1'b1;
    if (mode == 2) begin
      rx_data = 8'($urandom);
      rx_done = 1'b1;
    end
    @(posedge clk); #1;
    tx_done = 1'b0;
    if (mode == 2) begin
      rx_done = 1'b0;
      bump_err();
    end
  endtask

  // mode 3 injects an overrun byte in the cycle right after the address byte.
  task automatic do_load(input logic [7:0] addr, input int mode,
                         output logic [7:0] b_hi, output logic [7:0] b_lo, output int latency);
    int n;
    send_byte(8'h00);
    idle($urandom_range(0, 2));
    exp_q.push_back(mem_model[addr][15:8]);
    exp_q.push_back(mem_model[addr][7:0]);
    send_byte(addr);
    if (mode == 3) begin
      rx_data = 8'($urandom);
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      bump_err();
    end
    wait_tx(b_hi, n);
    latency = (mode == 3) ? n + 1 : n;
    check("load_latency", 32'(latency), 32'd2);
    respond((mode == 3) ? 0 : mode);
    wait_tx(b_lo, n);
    respond(0);
    @(negedge clk);
    check("busy_after_load", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [7:0] addr, input logic [15:0] data, output logic [7:0] b_ack);
    int n;
    b_ack = 8'h00;
    send_byte(8'h01);
    idle($urandom_range(0, 2));
    send_byte(addr);
    idle($urandom_range(0, 2));
    send_byte(data[15:8]);
    idle($urandom_range(0, 2));
`ifdef BITTY_MEM_STORE_ACK_EN
    exp_q.push_back(8'hA5);
`endif
    rx_data = data[7:0];
    rx_done = 1'b1;
    @(negedge clk);
    check("busy_in_store_frame", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rx_done = 1'b0;
    mem_model[addr] = data;
`ifdef BITTY_MEM_STORE_ACK_EN
    wait_tx(b_ack, n);
    check("ack_latency", 32'(n), 32'd1);
    respond(0);
    @(negedge clk);
    check("busy_after_ack", 32'(busy), 32'd0);
`else
    @(negedge clk);
    check("busy_after_store", 32'(busy), 32'd0);
    check("store_no_tx_en", 32'(tx_en), 32'd0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic bad_cmd(input logic [7:0] b);
    send_byte(b);
    bump_err();
    @(negedge clk);
    check("busy_after_bad_cmd", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_tx_en", 32'(tx_en), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // Never-written address reads as zero.
    do_load(8'h7F, 0, hi, lo, lat);
    check("load_unwritten_hi", 32'(hi), 32'h00);
    check("load_unwritten_lo", 32'(lo), 32'h00);

    // STORE then LOAD of the same word, high byte first.
    do_store(8'h10, 16'hBEEF, ack);
    do_load(8'h10, 0, hi, lo, lat);
    check("load_beef_hi", 32'(hi), 32'hBE);
    check("load_beef_lo", 32'(lo), 32'hEF);
    check("load_beef_latency", 32'(lat), 32'd2);

    // Invalid command byte, then a normal LOAD.
    bad_cmd(8'h5A);
    @(negedge clk);
    check("err_after_bad_cmd", 32'(err_cnt), 32'd1);
    check("no_tx_after_bad_cmd", 32'(tx_en), 32'd0);
    @(posedge clk); #1;
    do_load(8'h10, 0, hi, lo, lat);
    check("load_after_bad_hi", 32'(hi), 32'hBE);
    check("load_after_bad_lo", 32'(lo), 32'hEF);

    // Overrun during WAIT_HI leaves the response intact.
    do_load(8'h10, 1, hi, lo, lat);
    check("overrun_hi", 32'(hi), 32'hBE);
    check("overrun_lo", 32'(lo), 32'hEF);
    @(negedge clk);
    check("err_after_overrun", 32'(err_cnt), 32'd2);
    @(posedge clk); #1;

    // STORE acknowledgement (or silence without the ack feature).
    do_store(8'hFF, 16'h1234, ack);
`ifdef BITTY_MEM_STORE_ACK_EN
    check("store_ack_byte", 32'(ack), 32'hA5);
`endif
    do_load(8'hFF, 0, hi, lo, lat);
    check("load_1234_hi", 32'(hi), 32'h12);
    check("load_1234_lo", 32'(lo), 32'h34);

    // tx_done outside a WAIT state is ignored.
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("stray_tx_done_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Random mix of frames, overruns and stray strobes.
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 5);
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      case (op)
        0, 1: do_store(a, 16'($urandom), ack);
        2:    do_load(a, 0, hi, lo, lat);
        3:    do_load(a, $urandom_range(1, 3), hi, lo, lat);
        4:    bad_cmd(8'($urandom_range(2, 255)));
        default: begin
          tx_done = 1'b1;
          @(posedge clk); #1;
          tx_done = 1'b0;
          idle(1);
        end
      endcase
      idle($urandom_range(0, 3));
    end

    // Reset asserted in WAIT_LO abandons the frame and clears memory.
    do_store(8'h20, 16'hCAFE, ack);
    send_byte(8'h00);
    exp_q.push_back(8'hCA);
    exp_q.push_back(8'hFE);
    send_byte(8'h20);
    wait_tx(hi, lat);
    respond(0);
    wait_tx(lo, lat);
    check("pre_reset_lo", 32'(lo), 32'hFE);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    err_exp = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;
    #1;
    check("midreset_tx_en", 32'(tx_en), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_err_cnt", 32'(err_cnt), 32'd0);
    check("midreset_tx_data", 32'(tx_data), 32'd0);
    idle(2);
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("post_reset_tx_en", 32'(tx_en), 32'd0);
      check("post_reset_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    do_load(8'h20, 0, hi, lo, lat);
    check("cleared_word_hi", 32'(hi), 32'h00);
    check("cleared_word_lo", 32'(lo), 32'h00);

    // Error counter saturates at 0xFF.
    for (int i = 0; i < 260; i++) begin
      send_byte(8'($urandom_range(2, 255)));
      bump_err();
    end
    @(negedge clk);
    check("err_saturated", 32'(err_cnt), 32'hFF);
    @(posedge clk); #1;
    bad_cmd(8'h77);
    do_load(8'h7F, 0, hi, lo, lat);

    check("expected_bytes_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
